// File: rtl/regs_pkg.sv
// Register-block field widths shared by the UART peripheral.
package regs_pkg;

  localparam int unsigned CTRL_BAUD_WIDTH  = 2;
  localparam int unsigned LPMODE_DIV_WIDTH = 8;
  localparam int unsigned DATA_FIFO_WIDTH  = 8;

endpackage : regs_pkg

// File: rtl/uart_tx_pkg.sv
// Shared types and widths for the UART transmit sequencer.
package uart_tx_pkg;

  localparam int unsigned BIT_CYC_DEF  = 16;
  localparam int unsigned DATA_W       = regs_pkg::DATA_FIFO_WIDTH;
  localparam int unsigned BAUD_W       = regs_pkg::CTRL_BAUD_WIDTH;
  localparam int unsigned DIV_W        = regs_pkg::LPMODE_DIV_WIDTH;
  localparam int unsigned BAUD_SHIFT_W = $clog2(BIT_CYC_DEF);
  localparam int unsigned BITCNT_W     = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  // Bit-timing configuration captured once per frame.
  typedef struct packed {
    logic [BAUD_W-1:0] baud;
    logic              en;
    logic [DIV_W-1:0]  div;
  } timing_cfg_t;

endpackage : uart_tx_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period generator: (div+1) prescaler feeding a (BIT_CYC>>baud) cycle counter.
// bit_end_c_o is combinational and marks the last clock of each bit period.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned BIT_CYC = BIT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart_i,
  input  timing_cfg_t cfg_i,
  output logic        bit_end_c_o
);

  localparam int unsigned CYC_W = $clog2(BIT_CYC);

  logic [DIV_W-1:0] pre_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_max;
  logic             pre_last;

  // Terminal counts for the current configuration.
  always_comb begin
    cyc_max     = CYC_W'((32'(BIT_CYC) >> cfg_i.baud) - 32'd1);
    pre_last    = !cfg_i.en || (pre_q == cfg_i.div);
    bit_end_c_o = pre_last && (cyc_q == cyc_max);
  end

  // Prescaler and bit-period counters; restart keeps every frame phase-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cyc_q <= '0;
    end else if (restart_i) begin
      pre_q <= '0;
      cyc_q <= '0;
    end else if (pre_last) begin
      pre_q <= '0;
      cyc_q <= (cyc_q == cyc_max) ? '0 : cyc_q + CYC_W'(1);
    end else begin
      pre_q <= pre_q + DIV_W'(1);
    end
  end

endmodule : uart_baud_gen

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: drains the TX FIFO and serialises 8N1 frames.
// Optional feature macro UART_TX_PARITY_EN adds a parity bit (8E1/8O1) and parity_odd_i.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned BIT_CYC = BIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] ctrl_baud_i,
  input  logic              ctrl_txen_i,
  input  logic              ctrl_txst_i,
  input  logic              lpmode_en_i,
  input  logic [DIV_W-1:0]  lpmode_div_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd_i,
`endif
  output logic              fifo_rd_o,
  output logic              tx_o,
  output logic              stat_busy_o,
  output logic              intstat_tx_o
);

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  timing_cfg_t         cfg_q;
  logic                tx_q;
  logic                rd_q;
  logic                busy_q;
  logic                irq_q;
`ifdef UART_TX_PARITY_EN
  logic                par_q;
`endif
  logic                restart;
  logic                bit_end;

  // Timing counters sit at zero until the first START cycle of each frame.
  always_comb begin
    restart = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  end

  uart_baud_gen #(
    .BIT_CYC (BIT_CYC)
  ) u_baud_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_i   (restart),
    .cfg_i       (cfg_q),
    .bit_end_c_o (bit_end)
  );

  // Frame sequencer with registered line, pop, busy and interrupt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cfg_q    <= '0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      rd_q  <= 1'b0;
      irq_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (ctrl_txst_i && ctrl_txen_i && !fifo_empty_i) begin
            state_q <= ST_LOAD;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          shreg_q    <= fifo_data_i;
          cfg_q.baud <= ctrl_baud_i;
          cfg_q.en   <= lpmode_en_i;
          cfg_q.div  <= lpmode_div_i;
`ifdef UART_TX_PARITY_EN
          par_q      <= (^fifo_data_i) ^ parity_odd_i;
`endif
          bitcnt_q   <= '0;
          tx_q       <= 1'b0;
          state_q    <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bitcnt_q == BITCNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bitcnt_q <= bitcnt_q + BITCNT_W'(1);
              tx_q     <= shreg_q[0];
              shreg_q  <= {1'b0, shreg_q[DATA_W-1:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (ctrl_txen_i && !fifo_empty_i) begin
              state_q <= ST_LOAD;
              rd_q    <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              irq_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign fifo_rd_o    = rd_q;
  assign stat_busy_o  = busy_q;
  assign intstat_tx_o = irq_q;

endmodule : uart_tx_ctrl
